// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//   Assembles complete 65C02 instructions from the byte stream delivered by
//   data_bus_buffer. It predecodes the instruction length from the opcode and
//   requests one byte per phi2 cycle. It drives SYNC on opcode fetches and
//   hands the finished instruction to the execute stage over a valid/ready
//   handshake.
//
// Ports
//   phi2         clock, all state updates on the rising edge
//   resb         asynchronous active-low reset
//   flush        synchronous abort (branch taken, interrupt entry)
//   db_in        byte from data_bus_buffer
//   byte_valid   db_in holds a valid read byte this cycle
//   fetch_req    sequencer wants a byte this cycle
//   sync         the requested byte is an opcode fetch
//   pc_inc       one-cycle pulse after each accepted byte
//   instr_valid  opcode/operands hold a complete instruction
//   instr_ready  execute stage accepts the instruction
//   opcode, operand_lo, operand_hi, instr_len  the held instruction
//
// Parameters
//   BRK_LEN       length of opcode 8'h00 (1 or 2; anything else means 2)
//   RESET_OPCODE  opcode shown while nothing has been captured since reset
//
// Optional build macro
//   FORCE_BRK_ON_RESET_EN  reset lands in ISSUE holding a BRK (8'h00), so the
//                          reset sequence starts without a bus fetch.

module instruction_fetch_sequencer #(
  parameter int          BRK_LEN      = 2,
  parameter logic [7:0]  RESET_OPCODE = 8'hEA
) (
  input  logic       phi2,
  input  logic       resb,
  input  logic       flush,
  input  logic [7:0] db_in,
  input  logic       byte_valid,
  output logic       fetch_req,
  output logic       sync,
  output logic       pc_inc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand_lo,
  output logic [7:0] operand_hi,
  output logic [1:0] instr_len
);

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    ISSUE    = 2'd3
  } state_t;

  localparam logic [1:0] BRK_LEN_EFF = (BRK_LEN == 1) ? 2'd1 : 2'd2;

`ifdef FORCE_BRK_ON_RESET_EN
  localparam state_t     RST_STATE  = ISSUE;
  localparam logic [7:0] RST_OPCODE = 8'h00;
  localparam logic [1:0] RST_LEN    = BRK_LEN_EFF;
  localparam logic       RST_FETCH  = 1'b0;
  localparam logic       RST_SYNC   = 1'b0;
  localparam logic       RST_VALID  = 1'b1;
`else
  localparam state_t     RST_STATE  = FETCH_OP;
  localparam logic [7:0] RST_OPCODE = RESET_OPCODE;
  localparam logic [1:0] RST_LEN    = 2'd1;
  localparam logic       RST_FETCH  = 1'b1;
  localparam logic       RST_SYNC   = 1'b1;
  localparam logic       RST_VALID  = 1'b0;
`endif

  // Instruction length from the opcode nibbles (65C02 addressing-mode map).
  function automatic logic [1:0] predecode_len(input logic [7:0] op);
    logic [1:0] len_v;
    len_v = 2'd2;
    case (op[3:0])
      4'h0: begin
        if (op == 8'h00) begin
          len_v = BRK_LEN_EFF;
        end else if (op == 8'h20) begin
          len_v = 2'd3;
        end else if ((op == 8'h40) || (op == 8'h60)) begin
          len_v = 2'd1;
        end else begin
          len_v = 2'd2;
        end
      end
      4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7: len_v = 2'd2;
      4'h3, 4'h8, 4'hA, 4'hB:             len_v = 2'd1;
      4'h9:                               len_v = op[4] ? 2'd3 : 2'd2;
      4'hC, 4'hD, 4'hE, 4'hF:             len_v = 2'd3;
      default:                            len_v = 2'd2;
    endcase
    return len_v;
  endfunction

  state_t     state_r;
  state_t     seq_next_s;
  state_t     next_state_s;
  logic       fetch_req_r;
  logic       sync_r;
  logic       pc_inc_r;
  logic       instr_valid_r;
  logic [7:0] opcode_r;
  logic [7:0] operand_lo_r;
  logic [7:0] operand_hi_r;
  logic [1:0] instr_len_r;

  logic       accept_s;
  logic       take_s;
  logic       capture_op_s;
  logic       capture_lo_s;
  logic       capture_hi_s;
  logic [1:0] decoded_len_s;

  // A byte is consumed whenever it is requested and present; flush still
  // consumes it (pc_inc pulses) but discards its content.
  assign accept_s      = fetch_req_r & byte_valid;
  assign take_s        = accept_s & ~flush;
  assign decoded_len_s = predecode_len(db_in);

  // Next-state and capture-enable decode.
  always_comb begin
    seq_next_s   = state_r;
    capture_op_s = 1'b0;
    capture_lo_s = 1'b0;
    capture_hi_s = 1'b0;
    case (state_r)
      FETCH_OP: begin
        if (take_s) begin
          capture_op_s = 1'b1;
          seq_next_s   = (decoded_len_s == 2'd1) ? ISSUE : FETCH_LO;
        end else begin
          seq_next_s   = FETCH_OP;
        end
      end
      FETCH_LO: begin
        if (take_s) begin
          capture_lo_s = 1'b1;
          seq_next_s   = (instr_len_r == 2'd2) ? ISSUE : FETCH_HI;
        end else begin
          seq_next_s   = FETCH_LO;
        end
      end
      FETCH_HI: begin
        if (take_s) begin
          capture_hi_s = 1'b1;
          seq_next_s   = ISSUE;
        end else begin
          seq_next_s   = FETCH_HI;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          seq_next_s = FETCH_OP;
        end else begin
          seq_next_s = ISSUE;
        end
      end
      default: seq_next_s = FETCH_OP;
    endcase
    next_state_s = flush ? FETCH_OP : seq_next_s;
  end

  // State and registered control outputs, all derived from the next state.
  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      state_r       <= RST_STATE;
      fetch_req_r   <= RST_FETCH;
      sync_r        <= RST_SYNC;
      instr_valid_r <= RST_VALID;
      pc_inc_r      <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      fetch_req_r   <= (next_state_s != ISSUE);
      sync_r        <= (next_state_s == FETCH_OP);
      instr_valid_r <= (next_state_s == ISSUE);
      pc_inc_r      <= accept_s;
    end
  end

  // Instruction capture registers; held untouched through ISSUE and flush.
  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      opcode_r     <= RST_OPCODE;
      operand_lo_r <= 8'h00;
      operand_hi_r <= 8'h00;
      instr_len_r  <= RST_LEN;
    end else if (capture_op_s) begin
      opcode_r     <= db_in;
      operand_lo_r <= 8'h00;
      operand_hi_r <= 8'h00;
      instr_len_r  <= decoded_len_s;
    end else if (capture_lo_s) begin
      operand_lo_r <= db_in;
    end else if (capture_hi_s) begin
      operand_hi_r <= db_in;
    end
  end

  assign fetch_req   = fetch_req_r;
  assign sync        = sync_r;
  assign pc_inc      = pc_inc_r;
  assign instr_valid = instr_valid_r;
  assign opcode      = opcode_r;
  assign operand_lo  = operand_lo_r;
  assign operand_hi  = operand_hi_r;
  assign instr_len   = instr_len_r;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer. Stimulus pushes each
// expected instruction into a scoreboard queue; a monitor pops and compares
// on every valid/ready handshake. A second instance built with BRK_LEN=1
// shares the input stream to check the alternate BRK length.

module tb_instruction_fetch_sequencer;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] len;
  } exp_t;

`ifdef FORCE_BRK_ON_RESET_EN
  localparam bit FORCE_MODE = 1'b1;
`else
  localparam bit FORCE_MODE = 1'b0;
`endif

  logic       phi2 = 1'b0;
  logic       resb;
  logic       flush;
  logic [7:0] db_in;
  logic       byte_valid;
  logic       instr_ready;

  logic       fetch_req, sync, pc_inc, instr_valid;
  logic [7:0] opcode, operand_lo, operand_hi;
  logic [1:0] instr_len;

  logic       u1_fetch_req, u1_sync, u1_pc_inc, u1_instr_valid;
  logic [7:0] u1_opcode, u1_operand_lo, u1_operand_hi;
  logic [1:0] u1_instr_len;

  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   sync_acc_cnt = 0;
  int   pinc_cnt = 0;
  exp_t sb_q[$];

  instruction_fetch_sequencer u_dut (
    .phi2(phi2), .resb(resb), .flush(flush), .db_in(db_in),
    .byte_valid(byte_valid), .fetch_req(fetch_req), .sync(sync),
    .pc_inc(pc_inc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand_lo(operand_lo), .operand_hi(operand_hi),
    .instr_len(instr_len)
  );

  instruction_fetch_sequencer #(.BRK_LEN(1)) u_dut1 (
    .phi2(phi2), .resb(resb), .flush(flush), .db_in(db_in),
    .byte_valid(byte_valid), .fetch_req(u1_fetch_req), .sync(u1_sync),
    .pc_inc(u1_pc_inc), .instr_valid(u1_instr_valid), .instr_ready(instr_ready),
    .opcode(u1_opcode), .operand_lo(u1_operand_lo), .operand_hi(u1_operand_hi),
    .instr_len(u1_instr_len)
  );

  always #5 phi2 = ~phi2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    int n;
    n = 0;
    while (!fetch_req && n < 20) begin
      step();
      n++;
    end
    if (!fetch_req) chk("feed_wait", 32'(fetch_req), 32'd1);
    db_in      = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_fetch_req"},   32'(fetch_req),   FORCE_MODE ? 32'd0 : 32'd1);
    chk({tag, "_sync"},        32'(sync),        FORCE_MODE ? 32'd0 : 32'd1);
    chk({tag, "_pc_inc"},      32'(pc_inc),      32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), FORCE_MODE ? 32'd1 : 32'd0);
    chk({tag, "_opcode"},      32'(opcode),      FORCE_MODE ? 32'h00 : 32'hEA);
    chk({tag, "_operand_lo"},  32'(operand_lo),  32'h00);
    chk({tag, "_operand_hi"},  32'(operand_hi),  32'h00);
    chk({tag, "_instr_len"},   32'(instr_len),   FORCE_MODE ? 32'd2 : 32'd1);
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] lo,
                      input logic [7:0] hi, input logic [1:0] len);
    exp_t e;
    e.op  = op;
    e.lo  = lo;
    e.hi  = hi;
    e.len = len;
    sb_q.push_back(e);
  endtask

  // Monitor: counts accepts/pulses and checks every completed handshake.
  always @(negedge phi2) begin
    exp_t e;
    if (resb) begin
      if (fetch_req && byte_valid) acc_cnt++;
      if (fetch_req && byte_valid && sync) sync_acc_cnt++;
      if (pc_inc) pinc_cnt++;
      if (instr_valid && instr_ready && !flush) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got opcode %0h expected no instruction", opcode);
        end else begin
          e = sb_q.pop_front();
          chk("sb_opcode",     32'(opcode),     32'(e.op));
          chk("sb_operand_lo", 32'(operand_lo), 32'(e.lo));
          chk("sb_operand_hi", 32'(operand_hi), 32'(e.hi));
          chk("sb_instr_len",  32'(instr_len),  32'(e.len));
        end
      end
    end
  end

  initial begin
    logic [7:0] t_op  [6];
    logic [1:0] t_len [6];
    int a0, s0, p0;

    t_op  = '{8'h19, 8'h09, 8'hCB, 8'h0F, 8'h80, 8'h00};
    t_len = '{2'd3,  2'd2,  2'd1,  2'd3,  2'd2,  2'd2};

    resb        = 1'b0;
    flush       = 1'b0;
    db_in       = 8'h00;
    byte_valid  = 1'b0;
    instr_ready = 1'b0;
    #12;
    check_reset("reset");
    if (FORCE_MODE) push(8'h00, 8'h00, 8'h00, 2'd2);
    resb        = 1'b1;
    instr_ready = 1'b1;
    step();

    // 1-byte NOP: valid right after the accepting edge, no fetch during issue.
    push(8'hEA, 8'h00, 8'h00, 2'd1);
    feed(8'hEA);
    chk("nop_instr_valid", 32'(instr_valid), 32'd1);
    chk("nop_fetch_req",   32'(fetch_req),   32'd0);
    chk("nop_sync",        32'(sync),        32'd0);
    chk("nop_pc_inc",      32'(pc_inc),      32'd1);
    step();

    // 3-byte LDA abs: sync on the opcode only, three pc_inc pulses.
    a0 = acc_cnt; s0 = sync_acc_cnt; p0 = pinc_cnt;
    push(8'hAD, 8'h34, 8'h12, 2'd3);
    feed(8'hAD); feed(8'h34); feed(8'h12);
    step();
    chk("abs_accepts",   32'(acc_cnt - a0),      32'd3);
    chk("abs_sync_accs", 32'(sync_acc_cnt - s0), 32'd1);
    chk("abs_pc_incs",   32'(pinc_cnt - p0),     32'd3);

    // Stall in ISSUE while byte_valid toggles.
    instr_ready = 1'b0;
    push(8'hA9, 8'h7F, 8'h00, 2'd2);
    feed(8'hA9); feed(8'h7F);
    for (int i = 0; i < 5; i++) begin
      byte_valid = (i % 2 == 0);
      db_in      = 8'hFF;
      step();
      chk("stall_opcode",      32'(opcode),      32'hA9);
      chk("stall_operand_lo",  32'(operand_lo),  32'h7F);
      chk("stall_instr_valid", 32'(instr_valid), 32'd1);
      chk("stall_fetch_req",   32'(fetch_req),   32'd0);
    end
    byte_valid  = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("stall_release_valid", 32'(instr_valid), 32'd0);
    chk("stall_release_sync",  32'(sync),        32'd1);

    // Flush on the operand accept of JSR: byte discarded, pc_inc still pulses.
    feed(8'h20);
    db_in = 8'h55; byte_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; byte_valid = 1'b0;
    chk("flush_instr_valid", 32'(instr_valid), 32'd0);
    chk("flush_sync",        32'(sync),        32'd1);
    chk("flush_opcode",      32'(opcode),      32'h20);
    chk("flush_operand_lo",  32'(operand_lo),  32'h00);
    chk("flush_pc_inc",      32'(pc_inc),      32'd1);
    push(8'h60, 8'h00, 8'h00, 2'd1);
    feed(8'h60);
    chk("rts_instr_len", 32'(instr_len), 32'd1);
    step();

    // Length predecode table; 8'h00 checked on both BRK_LEN builds.
    for (int i = 0; i < 6; i++) begin
      push(t_op[i], (t_len[i] > 2'd1) ? 8'h5A : 8'h00,
           (t_len[i] > 2'd2) ? 8'hC3 : 8'h00, t_len[i]);
      feed(t_op[i]);
      if (t_op[i] == 8'h00) begin
        chk("brk1_instr_valid", 32'(u1_instr_valid), 32'd1);
        chk("brk1_instr_len",   32'(u1_instr_len),   32'd1);
      end
      if (t_len[i] > 2'd1) feed(8'h5A);
      if (t_len[i] > 2'd2) feed(8'hC3);
      step();
    end

    // Reset in FETCH_HI: outputs go to reset values at once.
    feed(8'hAD); feed(8'h34);
    #3;
    resb = 1'b0;
    #1;
    check_reset("midreset");
    a0 = acc_cnt;
    if (FORCE_MODE) push(8'h00, 8'h00, 8'h00, 2'd2);
    step();
    resb = 1'b1;
    step();
    chk("post_reset_accepts", 32'(acc_cnt - a0), 32'd0);
    push(8'hEA, 8'h00, 8'h00, 2'd1);
    feed(8'hEA);
    step();
    step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
